// File: rtl/mux_pkg.sv
// Shared constants and FSM state type for the 4:1 mux and its round-robin arbiter.
package mux_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between requesters/consumer (master side) and the arbiter (slave side).
interface mux_rr_arbiter_if #(
    parameter int N_REQ = mux_pkg::N_REQ,
    parameter int SEL_W = mux_pkg::SEL_W
);
    logic [N_REQ-1:0] req;
    logic             out_ready;
    logic [SEL_W-1:0] sel;
    logic [N_REQ-1:0] gnt;
    logic             out_valid;
    logic [N_REQ-1:0] ack;

    modport master (
        output req, out_ready,
        input  sel, gnt, out_valid, ack
    );

    modport slave (
        input  req, out_ready,
        output sel, gnt, out_valid, ack
    );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotated priority search: first set request starting at ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = mux_pkg::N_REQ,
    parameter int SEL_W = mux_pkg::SEL_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);
    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the last one written.
    always_comb begin
        any  = 1'b0;
        idx  = ptr;
        cand = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select, with valid/ready hold and winner ack.
module mux_rr_arbiter #(
    parameter int N_REQ     = mux_pkg::N_REQ,
    parameter int SEL_W     = mux_pkg::SEL_W,
    parameter int RESET_PTR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_rr_arbiter_if.slave     bus
);
    import mux_pkg::*;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             out_valid_q, out_valid_d;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                out_valid_d = 1'b0;
                if (pick_any) begin
                    sel_d           = pick_idx;
                    gnt_d[pick_idx] = 1'b1;
                    out_valid_d     = 1'b1;
                    state_d         = GRANT;
                end
            end
            GRANT: begin
                // Requests are ignored here; only the consumer can release the grant.
                if (bus.out_ready) begin
                    gnt_d       = '0;
                    out_valid_d = 1'b0;
                    ptr_d       = sel_q + SEL_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= SEL_W'(RESET_PTR);
            sel_q       <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ack       = (out_valid_q && bus.out_ready) ? gnt_q : '0;

    a_cfg: assert property (@(posedge clk) (N_REQ == 4) && (SEL_W == $clog2(N_REQ)));
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_gnt_vld: assert property (@(posedge clk) disable iff (!rst_n) ((gnt_q != '0) == out_valid_q));
endmodule
